// File: rtl/mdio_peripheral.sv
// Clause 22 management target: decodes controller-driven frames one bit per clk,
// holds a 32 x 16-bit register file and serialises read data back to the controller.
module mdio_peripheral #(
  parameter logic [4:0]  PHY_ADDR = 5'd0,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0CC2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_in,
  input  logic        mdio_oe_in,
  output logic        mdio_out,
  output logic        mdio_drv,
  output logic        wr_strobe,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_strobe,
  output logic        frame_err,
  output logic [5:0]  bit_cnt
);

  typedef enum logic [2:0] {StIdle, StHdr, StWdata, StRwait, StRdrive, StDrain} state_e;

  state_e      r_state, w_state_next;
  logic [15:0] r_shift;
  logic [5:0]  r_bit_cnt;
  logic [3:0]  r_tx_cnt;
  logic [4:0]  r_regad;
  logic [15:0] r_regs [32];
  logic        r_mdio_out, r_mdio_drv, r_wr_strobe, r_rd_strobe, r_frame_err;
  logic [4:0]  r_wr_addr;
  logic [15:0] r_wr_data;

  logic [15:0] w_shift_val;
  logic [15:0] w_rd_word;
  logic        w_shift_en, w_hdr_done, w_err, w_commit, w_load, w_tx_step, w_rd_done, w_drop;

  assign w_shift_val = {r_shift[14:0], mdio_in};

  always_comb begin
    if (r_regad == 5'd2) begin
      w_rd_word = PHY_ID1;
    end else if (r_regad == 5'd3) begin
      w_rd_word = PHY_ID2;
    end else begin
      w_rd_word = r_regs[r_regad];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_hdr_done   = 1'b0;
    w_err        = 1'b0;
    w_commit     = 1'b0;
    w_load       = 1'b0;
    w_tx_step    = 1'b0;
    w_rd_done    = 1'b0;
    w_drop       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (mdio_oe_in) begin
          w_shift_en   = 1'b1;
          w_state_next = StHdr;
        end
      end
      StHdr: begin
        if (!mdio_oe_in) begin
          w_err        = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_shift_en = 1'b1;
          // Header is judged on the cycle its 16th bit arrives
          if (r_bit_cnt == 6'd15) begin
            w_hdr_done = 1'b1;
            if (w_shift_val[15:14] != 2'b01 ||
                (w_shift_val[13:12] != 2'b01 && w_shift_val[13:12] != 2'b10)) begin
              w_err        = 1'b1;
              w_state_next = StDrain;
            end else if (w_shift_val[11:7] != PHY_ADDR) begin
              w_state_next = StDrain;
            end else if (w_shift_val[13:12] == 2'b01) begin
              w_state_next = StWdata;
            end else begin
              w_state_next = StRwait;
            end
          end
        end
      end
      StWdata: begin
        if (!mdio_oe_in) begin
          w_err        = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 6'd31) begin
            w_commit     = 1'b1;
            w_state_next = StDrain;
          end
        end
      end
      StRwait: begin
        if (!mdio_oe_in) begin
          w_load       = 1'b1;
          w_state_next = StRdrive;
        end
      end
      StRdrive: begin
        if (mdio_oe_in) begin
          w_drop       = 1'b1;
          w_err        = 1'b1;
          w_state_next = StDrain;
        end else if (r_tx_cnt == 4'd15) begin
          w_rd_done    = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_tx_step = 1'b1;
        end
      end
      StDrain: begin
        if (!mdio_oe_in) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_tx_cnt    <= '0;
      r_regad     <= '0;
      r_mdio_out  <= 1'b0;
      r_mdio_drv  <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_rd_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_wr_strobe <= w_commit;
      r_rd_strobe <= w_rd_done;
      r_frame_err <= w_err;
      if (w_shift_en) begin
        r_shift <= w_shift_val;
        if (r_bit_cnt != 6'd32) begin
          r_bit_cnt <= r_bit_cnt + 6'd1;
        end
      end
      if (w_state_next == StIdle) begin
        r_bit_cnt <= '0;
      end
      if (w_hdr_done) begin
        r_regad <= w_shift_val[6:2];
      end
      if (w_commit) begin
        r_wr_addr <= r_regad;
        r_wr_data <= w_shift_val;
        // ID registers are constants; the write is still reported
        if (r_regad != 5'd2 && r_regad != 5'd3) begin
          r_regs[r_regad] <= w_shift_val;
        end
      end
      if (w_load) begin
        r_shift    <= w_rd_word;
        r_mdio_out <= w_rd_word[15];
        r_mdio_drv <= 1'b1;
        r_tx_cnt   <= '0;
      end
      if (w_tx_step) begin
        r_mdio_out <= r_shift[14];
        r_shift    <= {r_shift[14:0], 1'b0};
        r_tx_cnt   <= r_tx_cnt + 4'd1;
      end
      if (w_rd_done || w_drop) begin
        r_mdio_out <= 1'b0;
        r_mdio_drv <= 1'b0;
      end
    end
  end

  assign mdio_out  = r_mdio_out;
  assign mdio_drv  = r_mdio_drv;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign rd_strobe = r_rd_strobe;
  assign frame_err = r_frame_err;
  assign bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_mdio_peripheral.sv
// Self-checking bench for mdio_peripheral: directed frames plus randomized
// reads/writes checked against an array model of the register file.
module tb_mdio_peripheral;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdio_in;
  logic        mdio_oe_in;
  logic        mdio_out;
  logic        mdio_drv;
  logic        wr_strobe;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_strobe;
  logic        frame_err;
  logic [5:0]  bit_cnt;

  always #5 clk = ~clk;

  mdio_peripheral dut (
    .clk        (clk),
    .reset      (reset),
    .mdio_in    (mdio_in),
    .mdio_oe_in (mdio_oe_in),
    .mdio_out   (mdio_out),
    .mdio_drv   (mdio_drv),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_strobe  (rd_strobe),
    .frame_err  (frame_err),
    .bit_cnt    (bit_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Free-running event monitor, sampled mid-cycle
  int          mon_wr = 0, mon_rd = 0, mon_err = 0, mon_drv = 0;
  logic [4:0]  mon_addr = '0;
  logic [15:0] mon_data = '0;
  logic [15:0] mon_rword = '0;

  always @(negedge clk) begin
    if (wr_strobe) begin
      mon_wr   <= mon_wr + 1;
      mon_addr <= wr_addr;
      mon_data <= wr_data;
    end
    if (rd_strobe) mon_rd <= mon_rd + 1;
    if (frame_err) mon_err <= mon_err + 1;
    if (mdio_drv) begin
      mon_drv   <= mon_drv + 1;
      mon_rword <= {mon_rword[14:0], mdio_out};
    end
  end

  logic [15:0] model_regs [32];

  function automatic logic [15:0] model_read(input logic [4:0] r);
    if (r == 5'd2) return 16'h0141;
    if (r == 5'd3) return 16'h0CC2;
    return model_regs[r];
  endfunction

  function automatic logic [15:0] hdr(input logic [1:0] st, input logic [1:0] op,
                                      input logic [4:0] phy, input logic [4:0] regad);
    return {st, op, phy, regad, 2'b10};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mdio_oe_in = 1'b1;
      mdio_in    = v[i];
      @(posedge clk); #1;
    end
    mdio_oe_in = 1'b0;
    mdio_in    = 1'b0;
  endtask

  task automatic frame(input logic [31:0] v, input int n, input int idle,
                       output int dwr, output int drd, output int derr, output int ddrv);
    int s_wr, s_rd, s_err, s_drv;
    s_wr = mon_wr; s_rd = mon_rd; s_err = mon_err; s_drv = mon_drv;
    send_bits(v, n);
    repeat (idle) begin
      @(posedge clk); #1;
    end
    dwr = mon_wr - s_wr; drd = mon_rd - s_rd; derr = mon_err - s_err; ddrv = mon_drv - s_drv;
  endtask

  task automatic do_read(input string tag, input logic [4:0] regad, input logic [15:0] exp);
    int dwr, drd, derr, ddrv;
    frame({16'h0, hdr(2'b01, 2'b10, 5'd0, regad)}, 16, 20, dwr, drd, derr, ddrv);
    check({tag, "_drv_cycles"}, 32'(ddrv), 32'd16);
    check({tag, "_data"}, 32'(mon_rword), 32'(exp));
    check({tag, "_rd_strobe"}, 32'(drd), 32'd1);
    check({tag, "_no_err"}, 32'(derr), 32'd0);
  endtask

  initial begin
    int dwr, drd, derr, ddrv;
    int s_rd;
    logic [4:0]  phy, regad;
    logic [15:0] data;
    logic        is_wr;

    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    reset = 1'b0; mdio_in = 1'b0; mdio_oe_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {25'(0), mdio_out, mdio_drv, wr_strobe, rd_strobe, frame_err, 1'b0, 1'b0},
          32'd0);
    check("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    check("rst_wr_bus", {11'(0), wr_addr, wr_data}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed write 0x5012_A5A5: strobe one cycle after the last bit
    send_bits(32'h5012_A5A5, 32);
    check("wr_strobe_lat", 32'(wr_strobe), 32'd1);
    check("wr_addr", 32'(wr_addr), 32'd4);
    check("wr_data", 32'(wr_data), 32'hA5A5);
    check("bit_cnt_sat", 32'(bit_cnt), 32'd32);
    @(posedge clk); #1;
    check("wr_strobe_single", 32'(wr_strobe), 32'd0);
    check("bit_cnt_idle", 32'(bit_cnt), 32'd0);
    model_regs[4] = 16'hA5A5;
    do_read("rd_reg4", 5'd4, 16'hA5A5);

    do_read("rd_id1", 5'd2, 16'h0141);
    do_read("rd_id2", 5'd3, 16'h0CC2);
    frame({hdr(2'b01, 2'b01, 5'd0, 5'd2), 16'hFFFF}, 32, 4, dwr, drd, derr, ddrv);
    check("wr_id_strobe", 32'(dwr), 32'd1);
    check("wr_id_addr", 32'(mon_addr), 32'd2);
    do_read("rd_id1_after_wr", 5'd2, 16'h0141);

    // Foreign PHYAD: completely silent
    frame({hdr(2'b01, 2'b01, 5'd5, 5'd4), 16'h1111}, 32, 4, dwr, drd, derr, ddrv);
    check("phy5_wr", 32'(dwr + derr + ddrv), 32'd0);
    frame({16'h0, hdr(2'b01, 2'b10, 5'd5, 5'd4)}, 16, 20, dwr, drd, derr, ddrv);
    check("phy5_rd", 32'(drd + derr + ddrv), 32'd0);

    frame({hdr(2'b00, 2'b01, 5'd0, 5'd4), 16'h1234}, 32, 4, dwr, drd, derr, ddrv);
    check("st00_err", 32'(derr), 32'd1);
    check("st00_no_wr", 32'(dwr), 32'd0);
    frame({hdr(2'b01, 2'b11, 5'd0, 5'd4), 16'h1234}, 32, 4, dwr, drd, derr, ddrv);
    check("op11_err", 32'(derr), 32'd1);
    check("op11_no_wr", 32'(dwr + ddrv), 32'd0);

    // Truncated frames
    frame({16'h0, hdr(2'b01, 2'b01, 5'd0, 5'd4)} >> 6, 10, 4, dwr, drd, derr, ddrv);
    check("trunc10_err", 32'(derr), 32'd1);
    check("trunc10_idle_cnt", 32'(bit_cnt), 32'd0);
    frame({hdr(2'b01, 2'b01, 5'd0, 5'd4), 16'h0000} >> 8, 24, 4, dwr, drd, derr, ddrv);
    check("trunc24_err", 32'(derr), 32'd1);
    check("trunc24_no_wr", 32'(dwr), 32'd0);
    do_read("rd_after_trunc", 5'd4, 16'hA5A5);

    // Bus contention while driving read data
    s_rd = mon_rd;
    dwr = mon_err;
    send_bits({16'h0, hdr(2'b01, 2'b10, 5'd0, 5'd4)}, 16);
    repeat (5) begin @(posedge clk); #1; end
    mdio_oe_in = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("contend_drop", 32'(mdio_drv), 32'd0);
    mdio_oe_in = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("contend_err", 32'(mon_err - dwr), 32'd1);
    check("contend_no_rd", 32'(mon_rd - s_rd), 32'd0);

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      phy   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      regad = 5'($urandom_range(0, 31));
      data  = 16'($urandom);
      is_wr = 1'($urandom_range(0, 1));
      if (is_wr) begin
        frame({hdr(2'b01, 2'b01, phy, regad), data}, 32, 4, dwr, drd, derr, ddrv);
        if (phy == 5'd0) begin
          check("rnd_wr_strobe", 32'(dwr), 32'd1);
          check("rnd_wr_bus", {11'(0), mon_addr, mon_data}, {11'(0), regad, data});
          if (regad != 5'd2 && regad != 5'd3) model_regs[regad] = data;
        end else begin
          check("rnd_wr_foreign", 32'(dwr + derr), 32'd0);
        end
      end else begin
        frame({16'h0, hdr(2'b01, 2'b10, phy, regad)}, 16, 20, dwr, drd, derr, ddrv);
        if (phy == 5'd0) begin
          check("rnd_rd_cycles", 32'(ddrv), 32'd16);
          check("rnd_rd_data", 32'(mon_rword), 32'(model_read(regad)));
          check("rnd_rd_strobe", 32'(drd), 32'd1);
        end else begin
          check("rnd_rd_foreign", 32'(ddrv + drd + derr), 32'd0);
        end
      end
    end

    // Reset while driving read data abandons the frame and clears the registers
    frame({hdr(2'b01, 2'b01, 5'd0, 5'd4), 16'hA5A5}, 32, 4, dwr, drd, derr, ddrv);
    s_rd = mon_rd;
    send_bits({16'h0, hdr(2'b01, 2'b10, 5'd0, 5'd4)}, 16);
    check("rwait_bit_cnt", 32'(bit_cnt), 32'd16);
    repeat (7) begin @(posedge clk); #1; end
    check("rdrive_active", 32'(mdio_drv), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_drv", {26'(0), mdio_drv, mdio_out, wr_strobe, rd_strobe, frame_err, 1'b0},
          32'd0);
    check("rst_mid_cnt", 32'(bit_cnt), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_no_rd_strobe", 32'(mon_rd - s_rd), 32'd0);
    do_read("rd_after_rst", 5'd4, model_read(5'd4));
    do_read("rd_id_after_rst", 5'd3, 16'h0CC2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
